shift_reg_burst: RTL and testbench
==================================

// Module: shift_reg_burst
//
// PURPOSE
//   Parametrised universal shift register: hold, parallel load, left and right shift.
//   Adds an autonomous burst mode: one start pulse shifts the register N positions
//   with no further control, then reports completion with a busy/done handshake.
//   Serial-in/parallel-out and parallel-in/serial-out building block for datapath
//   serialisers.
//
// PARAMETERS
//   WIDTH  8                     register width in bits (>=2)
//   CNT_W  $clog2(WIDTH)+1       width of amt_i and of the internal shift counter
//
// PORTS
//   clk     in   1       system clock; all state updates on rising edge
//   rst     in   1       reset; one clock; reset is synchronous and active-high
//   mode_i  in   2       0 hold, 1 parallel load, 2 shift left, 3 shift right
//   D       in   1       serial input bit, sampled on every shift edge
//   par_i   in   WIDTH   parallel load data
//   start_i in   1       start burst (modes 2/3 only)
//   amt_i   in   CNT_W   number of burst shifts, sampled with start_i
//   P       out  WIDTH   register contents
//   so_o    out  1       last bit shifted out (registered)
//   busy_o  out  1       burst in progress
//   done_o  out  1       one-cycle pulse, burst complete
//
// BEHAVIOUR
//   Reset: rst=1 at an edge forces P=0, so_o=0, busy_o=0, done_o=0, FSM=IDLE,
//     counter=0, latched direction=left; this applies in any state, including mid-burst.
//   Shift left: P <= {P[WIDTH-2:0], D}; so_o <= P[WIDTH-1].
//   Shift right: P <= {D, P[WIDTH-1:1]}; so_o <= P[0].
//   IDLE, start_i=0: direct single-edge ops per mode_i.
//     Mode 1 loads par_i. Modes 2/3 shift once and update so_o. Mode 0 holds.
//   IDLE, start_i=1, mode_i=0/1: start_i ignored; the direct op executes.
//   IDLE, start_i=1, mode_i=2/3 (acceptance edge):
//     - latch direction; cnt <= min(amt_i, WIDTH), so amt_i>WIDTH saturates to WIDTH;
//       P unchanged on this edge.
//     - amt_i!=0: go to BUSY; busy_o=1 from the next cycle.
//     - amt_i==0: stay IDLE; done_o=1 for the next cycle; P and so_o unchanged.
//   BUSY: each edge does one shift in the latched direction with the current D,
//     and decrements cnt.
//     - On the edge where cnt goes 1->0: return to IDLE, busy_o=0, done_o=1 for
//       exactly one cycle.
//     - Latency: the final P is visible after amt+1 edges counted from the acceptance edge.
//     - While BUSY, mode_i, par_i, start_i and amt_i are ignored; a start is not queued.
//   done_o is 0 in all other cycles. done_o and busy_o are never high together.
//   A start asserted in the same cycle done_o is high is accepted normally
//     (FSM is already IDLE).
//
// CONFIGURATION
//   SHIFT_REG_ROTATE_EN defined:
//     - adds input port rot_i (1 bit).
//     - Direct shifts sample rot_i on their own edge.
//     - Bursts sample rot_i on the acceptance edge and latch it for the whole burst.
//     - With rot_i=1, the inserted bit is the bit leaving the opposite end instead of D:
//       left inserts P[WIDTH-1], right inserts P[0]. so_o is updated as usual.
//   SHIFT_REG_ROTATE_EN undefined: rot_i does not exist; the inserted bit is always D.
//
// TESTING  (WIDTH=8)
//   1 Reset: mode_i=1, par_i=FF, rst=1 for 2 edges -> P=00, busy_o=0, done_o=0, so_o=0.
//   2 Load/direct: mode_i=1, par_i=A5 for 1 edge -> P=A5.
//     Then mode_i=2, D=1 for 1 edge -> P=4B, so_o=1.
//   3 Burst left: P=A5, start_i=1, mode_i=2, amt_i=3, D=1 -> busy_o high 3 cycles, P=2F,
//     so_o=1, done_o pulses once. Burst right from A5, amt_i=2, D=0 -> P=29, so_o=0.
//   4 Boundaries: amt_i=12, left, D=1 -> saturates to 8 shifts, P=FF.
//     start_i pulsed mid-burst -> ignored. amt_i=0 -> done_o next cycle, busy_o stays 0,
//     P unchanged.
//   5 Reset mid-burst: P=A5, left, amt_i=6, rst=1 after 2 shifts -> P=00, busy_o=0,
//     no done_o pulse.
//   6 [SHIFT_REG_ROTATE_EN] P=A5, rot_i=1, left, amt_i=4 -> P=5A.
//     Right, amt_i=1 -> P=2D, so_o=0.

Source files
------------

// File: rtl/shift_reg_burst.sv
// shift_reg_burst
//   Universal shift register with hold, parallel load, and left/right shift.
//   It also has an autonomous burst mode. A start pulse in a shift mode
//   shifts the register min(amt_i, WIDTH) times with no further control,
//   then pulses done_o.
//
// Parameters
//   WIDTH   register width (>= 2)
//   CNT_W   width of amt_i and of the burst counter
//
// Ports
//   clk      clock, rising edge
//   rst      synchronous active-high reset
//   mode_i   0 hold, 1 load, 2 shift left, 3 shift right
//   D        serial input bit
//   par_i    parallel load data
//   start_i  burst start (honoured only in modes 2/3 while idle)
//   amt_i    burst length, sampled with start_i
//   rot_i    rotate select (only when SHIFT_REG_ROTATE_EN is defined)
//   P        register contents
//   so_o     last bit shifted out
//   busy_o   burst in progress
//   done_o   one-cycle burst-complete pulse
//
// Build option
//   SHIFT_REG_ROTATE_EN  adds rot_i. When rot_i=1, the bit leaving one end
//                        is inserted at the other end instead of D.
module shift_reg_burst #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_i,
  input  logic             D,
  input  logic [WIDTH-1:0] par_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] amt_i,
`ifdef SHIFT_REG_ROTATE_EN
  input  logic             rot_i,
`endif
  output logic [WIDTH-1:0] P,
  output logic             so_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR} mode_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             so_q, so_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;   // 1 = right
  logic             rot_now;        // rotate select for a direct shift
  logic             rot_burst;      // rotate select for the running burst
  logic [CNT_W-1:0] amt_sat;
  mode_t            mode;

`ifdef SHIFT_REG_ROTATE_EN
  logic rot_q, rot_d;
  assign rot_now   = rot_i;
  assign rot_burst = rot_q;
`else
  assign rot_now   = 1'b0;
  assign rot_burst = 1'b0;
`endif

  assign mode    = mode_t'(mode_i);
  assign amt_sat = (amt_i > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amt_i;

  // Returns {shifted_out_bit, new_register}.
  function automatic logic [WIDTH:0] shift_fn(input logic [WIDTH-1:0] p,
                                              input logic right,
                                              input logic rot,
                                              input logic din);
    logic ins;
    if (right) begin
      ins = rot ? p[0] : din;
      return {p[0], ins, p[WIDTH-1:1]};
    end else begin
      ins = rot ? p[WIDTH-1] : din;
      return {p[WIDTH-1], p[WIDTH-2:0], ins};
    end
  endfunction

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    so_d    = so_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
`ifdef SHIFT_REG_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i && (mode == MODE_SHL || mode == MODE_SHR)) begin
          // Acceptance edge: latch the burst setup. P and so_o do not change.
          dir_d = (mode == MODE_SHR);
          cnt_d = amt_sat;
`ifdef SHIFT_REG_ROTATE_EN
          rot_d = rot_i;
`endif
          if (amt_sat != '0) begin
            state_d = BUSY;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          case (mode)
            MODE_LOAD: p_d = par_i;
            MODE_SHL:  {so_d, p_d} = shift_fn(p_q, 1'b0, rot_now, D);
            MODE_SHR:  {so_d, p_d} = shift_fn(p_q, 1'b1, rot_now, D);
            default:   p_d = p_q;
          endcase
        end
      end
      BUSY: begin
        {so_d, p_d} = shift_fn(p_q, dir_q, rot_burst, D);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      so_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
`ifdef SHIFT_REG_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      so_q    <= so_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
`ifdef SHIFT_REG_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign P      = p_q;
  assign so_o   = so_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_shift_reg_burst.sv
// Testbench for shift_reg_burst (WIDTH=8).
// The stimulus drives one operation per clock and queues the state the
// register should show after that edge. A monitor compares on the falling
// edge. A second queue holds the P value expected with each done_o pulse.
module tb_shift_reg_burst;
  localparam int W  = 8;
  localparam int CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode_i;
  logic          D;
  logic [W-1:0]  par_i;
  logic          start_i;
  logic [CW-1:0] amt_i;
  logic          rot;
  logic [W-1:0]  P;
  logic          so_o, busy_o, done_o;

  always #5 clk = ~clk;

  shift_reg_burst #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .D(D), .par_i(par_i),
    .start_i(start_i), .amt_i(amt_i),
`ifdef SHIFT_REG_ROTATE_EN
    .rot_i(rot),
`endif
    .P(P), .so_o(so_o), .busy_o(busy_o), .done_o(done_o)
  );

  typedef struct {
    logic [W-1:0] p;
    logic         so;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] done_exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference state
  logic [W-1:0] m_p  = '0;
  logic         m_so = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("P",      32'(P),      32'(e.p));
        check("so_o",   32'(so_o),   32'(e.so));
        check("busy_o", 32'(busy_o), 32'(e.busy));
        check("done_o", 32'(done_o), 32'(e.done));
        check("busy_done_excl", 32'(busy_o & done_o), 32'd0);
      end
      if (done_o === 1'b1) begin
        if (done_exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else check("done_P", 32'(P), 32'(done_exp_q.pop_front()));
      end
    end
  end

  function automatic logic rot_eff(input logic r);
`ifdef SHIFT_REG_ROTATE_EN
    return r;
`else
    return 1'b0 & r;
`endif
  endfunction

  // One shift of the reference register.
  task automatic model_shift(input bit right, input logic d, input logic r);
    logic ins;
    if (!right) begin
      ins  = rot_eff(r) ? m_p[W-1] : d;
      m_so = m_p[W-1];
      m_p  = (m_p << 1) | W'(ins);
    end else begin
      ins  = rot_eff(r) ? m_p[0] : d;
      m_so = m_p[0];
      m_p  = (m_p >> 1) | (W'(ins) << (W - 1));
    end
  endtask

  task automatic cycle(input logic r, input logic [1:0] md, input logic d,
                       input logic [W-1:0] par, input logic st,
                       input logic [CW-1:0] amt, input logic rt, input exp_t e);
    rst = r; mode_i = md; D = d; par_i = par; start_i = st; amt_i = amt; rot = rt;
    @(posedge clk);
    exp_q.push_back(e);
    if (e.done) done_exp_q.push_back(e.p);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] md, input logic [W-1:0] par);
    m_p = '0; m_so = 1'b0;
    cycle(1'b1, md, 1'($urandom), par, 1'($urandom), CW'($urandom), 1'($urandom),
          '{p: m_p, so: m_so, busy: 1'b0, done: 1'b0});
  endtask

  // Direct single-edge op. A start is passed only with modes 0/1, where it is ignored.
  task automatic do_direct(input logic [1:0] md, input logic d, input logic [W-1:0] par,
                           input logic st, input logic rt);
    if (md == 2'd1) m_p = par;
    else if (md == 2'd2) model_shift(1'b0, d, rt);
    else if (md == 2'd3) model_shift(1'b1, d, rt);
    cycle(1'b0, md, d, par, (md[1] ? 1'b0 : st), CW'($urandom), rt,
          '{p: m_p, so: m_so, busy: 1'b0, done: 1'b0});
  endtask

  // dmode: 0 drives D=0, 1 drives D=1, 2 drives random D.
  // rst_at: the shift index at which reset is applied (0 means no reset).
  task automatic do_burst(input bit right, input int amt, input logic rt,
                          input int dmode, input int rst_at, input bit poke);
    int   eff;
    logic d;
    eff = (amt > W) ? W : amt;
    cycle(1'b0, right ? 2'd3 : 2'd2, 1'($urandom), W'($urandom), 1'b1, CW'(amt), rt,
          '{p: m_p, so: m_so, busy: (eff != 0), done: (eff == 0)});
    for (int k = 1; k <= eff; k++) begin
      if (k == rst_at) begin
        do_reset(2'($urandom), W'($urandom));
        return;
      end
      d = (dmode == 2) ? 1'($urandom) : 1'(dmode);
      model_shift(right, d, rt);
      cycle(1'b0, 2'($urandom), d, W'($urandom), poke ? 1'($urandom) : 1'b0,
            CW'($urandom), 1'($urandom),
            '{p: m_p, so: m_so, busy: (k < eff), done: (k == eff)});
    end
  endtask

  initial begin
    // Reset while loading
    do_reset(2'd1, 8'hFF);
    do_reset(2'd1, 8'hFF);
    // Load, then one direct left shift: A5 -> 4B, so_o=1
    do_direct(2'd1, 1'b0, 8'hA5, 1'b0, 1'b0);
    do_direct(2'd2, 1'b1, 8'h00, 1'b0, 1'b0);
    // Burst left 3 with D=1: A5 -> 2F
    do_direct(2'd1, 1'b0, 8'hA5, 1'b1, 1'b0);
    do_burst(1'b0, 3, 1'b0, 1, 0, 1'b0);
    // Burst right 2 with D=0: A5 -> 29
    do_direct(2'd1, 1'b0, 8'hA5, 1'b0, 1'b0);
    do_burst(1'b1, 2, 1'b0, 0, 0, 1'b0);
    // Saturating burst with starts pulsed mid-burst, then a zero-length burst
    do_burst(1'b0, 12, 1'b0, 1, 0, 1'b1);
    do_burst(1'b0, 0, 1'b0, 2, 0, 1'b0);
    do_direct(2'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    // Reset after two shifts of a 6-shift burst
    do_direct(2'd1, 1'b0, 8'hA5, 1'b0, 1'b0);
    do_burst(1'b0, 6, 1'b0, 2, 3, 1'b0);
    do_direct(2'd0, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef SHIFT_REG_ROTATE_EN
    // Rotate left 4 (A5 -> 5A), then rotate right 1 (-> 2D)
    do_direct(2'd1, 1'b0, 8'hA5, 1'b0, 1'b0);
    do_burst(1'b0, 4, 1'b1, 2, 0, 1'b0);
    do_burst(1'b1, 1, 1'b1, 2, 0, 1'b0);
`endif
    // Random mix; bursts run back-to-back so a start can coincide with done_o
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 55)
        do_direct(2'($urandom), 1'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      else if (sel < 95)
        do_burst(1'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 2,
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 8)) : 0,
                 1'($urandom));
      else
        do_reset(2'($urandom), W'($urandom));
    end
    do_direct(2'd0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    check("exp_queue_drained",  32'(exp_q.size()),      32'd0);
    check("done_queue_drained", 32'(done_exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
